// File: rtl/ysyx_24100006_id_exe_reg.sv
// ---------------------------------------------------------------------------
// ysyx_24100006_id_exe_reg
//
// Pipeline register between the decode stage (IDU) and the execute stage
// (EXEU), built as a two-entry skid buffer. The "main" entry drives the *_E
// outputs. The "skid" entry catches one extra payload that was accepted in
// the same cycle EXEU stalled. Because of the skid entry, id_in_ready can come
// straight from a flop and needs no combinational path from exe_out_ready.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   id_in_valid       IDU payload valid
//   id_in_ready       block can accept a payload (registered)
//   exe_out_valid     main entry holds a payload for EXEU (registered)
//   exe_out_ready     EXEU accepts the main entry
//   flush             redirect/exception kill; empties the buffer at the
//                     next edge and discards any same-cycle input
//   <field>_D/_E      decoded payload fields, input side / output side
//
// Optional feature
//   YSYX_24100006_IDEXE_PC_TRACE_EN : adds pc_D/pc_E. The pc is carried
//   through main and skid like any other payload field.
// ---------------------------------------------------------------------------
module ysyx_24100006_id_exe_reg (
    input  logic        clk,
    input  logic        reset,

    input  logic        id_in_valid,
    output logic        id_in_ready,
    output logic        exe_out_valid,
    input  logic        exe_out_ready,
    input  logic        flush,

`ifdef YSYX_24100006_IDEXE_PC_TRACE_EN
    input  logic [31:0] pc_D,
    output logic [31:0] pc_E,
`endif

    input  logic [3:0]  aluop_D,
    input  logic        Gpr_Write_D,
    input  logic        Csr_Write_D,
    input  logic [3:0]  Gpr_Write_Addr_D,
    input  logic [11:0] Csr_Write_Addr_D,
    input  logic [1:0]  Gpr_Write_RD_D,
    input  logic [2:0]  Jump_D,
    input  logic [1:0]  sram_read_write_D,
    input  logic [2:0]  Mem_Mask_D,
    input  logic        irq_D,
    input  logic        is_fence_i_D,
    input  logic [31:0] pc_j_m_e_n_D,
    input  logic [31:0] alu_a_data_D,
    input  logic [31:0] alu_b_data_D,
    input  logic [31:0] pc_add_imm_D,
    input  logic [31:0] wdata_csr_D,
    input  logic [31:0] wdata_gpr_D,
    input  logic [31:0] pc_add_4_D,

    output logic [3:0]  aluop_E,
    output logic        Gpr_Write_E,
    output logic        Csr_Write_E,
    output logic [3:0]  Gpr_Write_Addr_E,
    output logic [11:0] Csr_Write_Addr_E,
    output logic [1:0]  Gpr_Write_RD_E,
    output logic [2:0]  Jump_E,
    output logic [1:0]  sram_read_write_E,
    output logic [2:0]  Mem_Mask_E,
    output logic        irq_E,
    output logic        is_fence_i_E,
    output logic [31:0] pc_j_m_e_n_E,
    output logic [31:0] alu_a_data_E,
    output logic [31:0] alu_b_data_E,
    output logic [31:0] pc_add_imm_E,
    output logic [31:0] wdata_csr_E,
    output logic [31:0] wdata_gpr_E,
    output logic [31:0] pc_add_4_E
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
`ifdef YSYX_24100006_IDEXE_PC_TRACE_EN
        logic [31:0] pc;
`endif
        logic [3:0]  aluop;
        logic        gpr_write;
        logic        csr_write;
        logic [3:0]  gpr_write_addr;
        logic [11:0] csr_write_addr;
        logic [1:0]  gpr_write_rd;
        logic [2:0]  jump;
        logic [1:0]  sram_read_write;
        logic [2:0]  mem_mask;
        logic        irq;
        logic        is_fence_i;
        logic [31:0] pc_j_m_e_n;
        logic [31:0] alu_a_data;
        logic [31:0] alu_b_data;
        logic [31:0] pc_add_imm;
        logic [31:0] wdata_csr;
        logic [31:0] wdata_gpr;
        logic [31:0] pc_add_4;
    } payload_t;

    state_e   state_q, state_d;
    payload_t main_q, main_d;
    payload_t skid_q, skid_d;
    payload_t in_pl_s;
    logic     ready_q;
    logic     valid_q;
    logic     in_fire_s;
    logic     out_fire_s;

    // Pack the input-side fields into one payload word.
    always_comb begin
        in_pl_s                 = '0;
`ifdef YSYX_24100006_IDEXE_PC_TRACE_EN
        in_pl_s.pc              = pc_D;
`endif
        in_pl_s.aluop           = aluop_D;
        in_pl_s.gpr_write       = Gpr_Write_D;
        in_pl_s.csr_write       = Csr_Write_D;
        in_pl_s.gpr_write_addr  = Gpr_Write_Addr_D;
        in_pl_s.csr_write_addr  = Csr_Write_Addr_D;
        in_pl_s.gpr_write_rd    = Gpr_Write_RD_D;
        in_pl_s.jump            = Jump_D;
        in_pl_s.sram_read_write = sram_read_write_D;
        in_pl_s.mem_mask        = Mem_Mask_D;
        in_pl_s.irq             = irq_D;
        in_pl_s.is_fence_i      = is_fence_i_D;
        in_pl_s.pc_j_m_e_n      = pc_j_m_e_n_D;
        in_pl_s.alu_a_data      = alu_a_data_D;
        in_pl_s.alu_b_data      = alu_b_data_D;
        in_pl_s.pc_add_imm      = pc_add_imm_D;
        in_pl_s.wdata_csr       = wdata_csr_D;
        in_pl_s.wdata_gpr       = wdata_gpr_D;
        in_pl_s.pc_add_4        = pc_add_4_D;
    end

    // ready_q is low only in TWO, so in_fire can never happen in TWO.
    assign in_fire_s  = id_in_valid & ready_q;
    assign out_fire_s = valid_q & exe_out_ready;

    // Next-state and payload-movement logic. Flush overrides everything.
    // Payload registers are left as they are on flush.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire_s) begin
                        state_d = ONE;
                        main_d  = in_pl_s;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        state_d = ONE;
                        main_d  = in_pl_s;
                    end else if (in_fire_s) begin
                        // EXEU stalled: park the newer payload behind main.
                        state_d = TWO;
                        skid_d  = in_pl_s;
                    end else if (out_fire_s) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                TWO: begin
                    if (out_fire_s) begin
                        // The older payload left, so the skid entry moves up into main.
                        state_d = ONE;
                        main_d  = skid_q;
                    end else begin
                        state_d = TWO;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State, handshake flops and payload storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != TWO);
            valid_q <= (state_d != EMPTY);
        end
    end

    assign id_in_ready   = ready_q;
    assign exe_out_valid = valid_q;

    // Side-effecting controls are masked so a stale main entry can never
    // trigger a write, memory access, fence or interrupt.
    assign Gpr_Write_E       = main_q.gpr_write  & valid_q;
    assign Csr_Write_E       = main_q.csr_write  & valid_q;
    assign is_fence_i_E      = main_q.is_fence_i & valid_q;
    assign irq_E             = main_q.irq        & valid_q;
    assign sram_read_write_E = main_q.sram_read_write & {2{valid_q}};

`ifdef YSYX_24100006_IDEXE_PC_TRACE_EN
    assign pc_E              = main_q.pc;
`endif
    assign aluop_E           = main_q.aluop;
    assign Gpr_Write_Addr_E  = main_q.gpr_write_addr;
    assign Csr_Write_Addr_E  = main_q.csr_write_addr;
    assign Gpr_Write_RD_E    = main_q.gpr_write_rd;
    assign Jump_E            = main_q.jump;
    assign Mem_Mask_E        = main_q.mem_mask;
    assign pc_j_m_e_n_E      = main_q.pc_j_m_e_n;
    assign alu_a_data_E      = main_q.alu_a_data;
    assign alu_b_data_E      = main_q.alu_b_data;
    assign pc_add_imm_E      = main_q.pc_add_imm;
    assign wdata_csr_E       = main_q.wdata_csr;
    assign wdata_gpr_E       = main_q.wdata_gpr;
    assign pc_add_4_E        = main_q.pc_add_4;

endmodule

// File: doc/ysyx_24100006_id_exe_reg.md
YSYX_24100006_ID_EXE_REG -- requirements
Module: ysyx_24100006_id_exe_reg

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 SHALL use one clock and an asynchronous, active-high reset, named as follows:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-high
REQ-003 SHALL have these handshake and control ports:
- id_in_valid  in  1  IDU payload valid
- id_in_ready  out  1  block can accept (registered)
- exe_out_valid  out  1  payload to EXEU valid
- exe_out_ready  in  1  EXEU accepts
- flush  in  1  redirect/exception kill
REQ-004 SHALL carry these payload fields, each as <field>_D input and <field>_E output at the same width:
- aluop 4; Gpr_Write 1; Csr_Write 1; Gpr_Write_Addr 4; Csr_Write_Addr 12
- Gpr_Write_RD 2; Jump 3; sram_read_write 2; Mem_Mask 3; irq 1; is_fence_i 1
- 32-bit: pc_j_m_e_n, alu_a_data, alu_b_data, pc_add_imm, wdata_csr, wdata_gpr, pc_add_4

Function
REQ-005 SHALL implement a two-entry skid buffer (main, skid) with states EMPTY, ONE, TWO; main drives the *_E outputs.
REQ-006 SHALL define handshake events as:
- in_fire = id_in_valid & id_in_ready
- out_fire = exe_out_valid & exe_out_ready
REQ-007 SHALL make these transitions in EMPTY:
- in_fire -> ONE, main loaded
- otherwise hold
REQ-008 SHALL make these transitions in ONE:
- in_fire & out_fire -> ONE, main reloaded
- in_fire & !out_fire -> TWO, skid loaded
- out_fire only -> EMPTY
REQ-009 SHALL make this transition in TWO: out_fire -> ONE, main <= skid; in_fire cannot occur in TWO.
REQ-010 SHALL drive id_in_ready = (state != TWO) from a flop, with no combinational path from exe_out_ready.
REQ-011 SHALL drive exe_out_valid = (state != EMPTY).
REQ-012 SHALL have a latency of one cycle from in_fire to the payload appearing on *_E, and sustain one transfer per cycle while exe_out_ready stays high.
REQ-013 SHALL force Gpr_Write_E, Csr_Write_E, is_fence_i_E, irq_E and sram_read_write_E to 0 whenever exe_out_valid is 0.
REQ-014 SHALL move to EMPTY on flush at the next edge:
- any same-cycle in_fire is discarded
- flush has priority over all other transitions
- payload registers need not be cleared
REQ-015 SHALL hold the main payload stable while exe_out_valid=1 and exe_out_ready=0.
REQ-016 SHALL preserve ordering: the skid entry never bypasses main.

Reset
REQ-017 SHALL, while reset is asserted:
- set state=EMPTY, exe_out_valid=0, id_in_ready=1
- clear all main and skid payload registers to 0
REQ-018 SHALL abandon any transfer in progress when reset asserts mid-operation, with nothing delivered afterwards.

Configuration
REQ-019 SHALL, with YSYX_24100006_IDEXE_PC_TRACE_EN defined:
- add ports pc_D (in, 32) and pc_E (out, 32)
- carry pc through main and skid like any payload field
- reset pc to 0
REQ-020 SHALL, without YSYX_24100006_IDEXE_PC_TRACE_EN, omit both ports and their registers; all other behaviour is unchanged.

Verification
REQ-021 Streaming: id_in_valid=1 and exe_out_ready=1 for 4 cycles with alu_a_data_D=1,2,3,4 -> exe_out_valid=1 from cycle 1, alu_a_data_E=1,2,3,4 on consecutive cycles, id_in_ready constantly 1.
REQ-022 Stall: exe_out_ready=0, send A=0x10 then B=0x20 -> state TWO, id_in_ready=0, alu_a_data_E holds 0x10. Raise ready -> 0x10 then 0x20 delivered, id_in_ready returns 1.
REQ-023 Flush: in TWO, assert flush together with id_in_valid carrying 0x30 -> next cycle exe_out_valid=0, id_in_ready=1, 0x30 never appears.
REQ-024 Gating: hold exe_out_valid=0 after a Gpr_Write_D=1 entry has been consumed -> Gpr_Write_E=0, Csr_Write_E=0, sram_read_write_E=0.
REQ-025 Reset: assert reset asynchronously mid-stream in state ONE -> exe_out_valid=0 immediately without a clock edge, and all *_E outputs read 0.
REQ-026 Macro: build with YSYX_24100006_IDEXE_PC_TRACE_EN, pc_D=0x80000000 -> pc_E=0x80000000 one cycle after in_fire; build without the macro -> the pc ports are absent.
